decode_buffer_stage: RTL and testbench
======================================

Name: decode_buffer_stage

Overview:
Parametrised fetch-to-decode stage. It replaces the single D register with a DEPTH-entry circular instruction queue. The head entry drives the D_* decoded fields toward execute. d_allow_in depends only on queue occupancy, which removes the combinational e_allow_in → d_allow_in path. Load-use hazard detection is qualified by source-register use and rd≠x0; mispredict flush empties the whole queue; a saturating stall counter supports performance analysis.

Parameters:
DEPTH, 4, queue entries; power of two, ≥2
N, 12, branch-predictor history width
XLEN, 32, pc/immediate/instruction width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
f_to_d_valid  input  1  fetch offers an instruction
d_allow_in  output  1  queue can accept this cycle
e_allow_in  input  1  execute accepts this cycle
d_to_e_valid  output  1  head is valid and hazard-free
fact_success  input  1  execute's branch prediction was correct
e_is_jump_instr  input  1  execute holds a jump/branch
e_valid  input  1  execute stage valid
E_opcode  input  7  execute opcode
E_rd  input  5  execute destination register
F_pc, f_default_pc, f_imm, f_instr  input  XLEN each  fetch pc, pc+4, immediate, raw instruction
f_opcode  input  7  fetch opcode
f_rd, f_rs1, f_rs2  input  5 each  fetch register fields
f_funct  input  10  fetch funct7/funct3
f_instr_type  input  3  fetch instruction type
f_is_jump_instr, f_pred_taken  input  1 each  fetch jump flag, prediction
f_pred_history  input  N  fetch prediction history
D_pc, D_default_pc, D_imm, D_instr, D_cur_pc, D_pred_pc  output  XLEN each  head fields
D_opcode  output  7  head opcode
D_rd, D_rs1, D_rs2  output  5 each  head register fields
D_funct  output  10  head funct
D_instr_type  output  3  head type
D_is_jump_instr, D_pred_taken, D_commit  output  1 each  head flags
D_pred_history  output  N  head history
d_count  output  $clog2(DEPTH)+1  occupancy
d_stall_cnt  output  32  load-use stall cycles, saturating

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, d_count=0, d_stall_cnt=0, d_to_e_valid=0, d_allow_in=1. Entry storage is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy counter is $clog2(DEPTH)+1 bits.
- d_allow_in = (d_count != DEPTH). It must not depend on e_allow_in. When full, no push is accepted, even if a pop occurs in the same cycle.
- push = f_to_d_valid & d_allow_in & ~flush. On push, write all f_* fields into entry[wr_ptr]; D_cur_pc and D_pc both get F_pc.
- On push, D_pred_pc gets f_default_pc, and D_commit gets (F_pc ≥ 32'h80000000 && F_pc ≤ 32'h87ffffff).
- Head outputs D_* read entry[rd_ptr] combinationally. When the queue is empty, D_* are stale and must be ignored.
- Source use: src1 is used for `TYPER/`TYPEI/`TYPES/`TYPEB; src2 for `TYPER/`TYPES/`TYPEB. Type encodings come from define.v.
- load_use = e_valid & (E_opcode==`OP_LOAD) & (E_rd≠0) & ((src1 & E_rd==D_rs1) | (src2 & E_rd==D_rs2)).
- d_to_e_valid = (d_count≠0) & ~load_use.
- pop = d_to_e_valid & e_allow_in & ~flush. A pop advances rd_ptr by 1.
- Simultaneous push and pop: d_count is unchanged and both pointers advance.
- flush = ~fact_success & e_is_jump_instr & e_valid. Flush has priority over everything. Next cycle: d_count=0, rd_ptr=wr_ptr=0, and any same-cycle push or pop is discarded.
- d_stall_cnt increments by 1 each cycle that (d_count≠0) & load_use & ~flush. It holds at 32'hFFFFFFFF.
- Zero-latency bypass is not provided: an instruction pushed in cycle T is visible at the head in T+1 at the earliest.

Test Plan:
- Reset then push 4 instrs (pc 0x80000000..0x8000000C) with e_allow_in=0 → d_count=4, d_allow_in=0; 5th offer is ignored; D_pc=0x80000000, D_commit=1.
- Full queue, e_allow_in=1 with continuous fetch → one pop per cycle; head order is 0x80000000, 0x80000004, …; a push happens only in cycles where d_count<4; no entry is lost or duplicated.
- Occupancy 2, simultaneous push/pop for 10 cycles crossing pointer wrap → d_count stays 2; FIFO order is preserved across wrap.
- E: lw x5 with e_valid=1; head add x6,x5,x1 → d_to_e_valid=0, d_stall_cnt increments. Repeat with head lui x5 (no source) or E_rd=0 → no stall.
- d_count=3, flush asserted together with f_to_d_valid=1 → next cycle d_count=0, d_to_e_valid=0; the following push appears at the head.
- Force d_stall_cnt=32'hFFFFFFFE, then hold a hazard for 3 cycles → value reaches 32'hFFFFFFFF and stays there. Assert rst mid-operation → all counters and pointers return to 0 next cycle.

Source files
------------

// File: rtl/decode_buffer_stage_if.sv
// decode_buffer_stage_if
//   Bundle of every non-clock/reset signal of the decode buffer stage.
//   slave  : the decode buffer itself (takes fetch/execute inputs, drives D_*).
//   master : the environment around it (fetch + execute side).
//   Groups: fetch handshake + fields (f_*), execute feedback (e_*, E_*),
//           head outputs (D_*), occupancy / stall statistics.
interface decode_buffer_stage_if #(
  parameter int DEPTH = 4,
  parameter int N     = 12,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // handshake
  logic            f_to_d_valid;
  logic            d_allow_in;
  logic            e_allow_in;
  logic            d_to_e_valid;

  // execute feedback
  logic            fact_success;
  logic            e_is_jump_instr;
  logic            e_valid;
  logic [6:0]      E_opcode;
  logic [4:0]      E_rd;

  // fetch fields
  logic [XLEN-1:0] F_pc;
  logic [XLEN-1:0] f_default_pc;
  logic [XLEN-1:0] f_imm;
  logic [XLEN-1:0] f_instr;
  logic [6:0]      f_opcode;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [9:0]      f_funct;
  logic [2:0]      f_instr_type;
  logic            f_is_jump_instr;
  logic            f_pred_taken;
  logic [N-1:0]    f_pred_history;

  // head fields
  logic [XLEN-1:0] D_pc;
  logic [XLEN-1:0] D_default_pc;
  logic [XLEN-1:0] D_imm;
  logic [XLEN-1:0] D_instr;
  logic [XLEN-1:0] D_cur_pc;
  logic [XLEN-1:0] D_pred_pc;
  logic [6:0]      D_opcode;
  logic [4:0]      D_rd;
  logic [4:0]      D_rs1;
  logic [4:0]      D_rs2;
  logic [9:0]      D_funct;
  logic [2:0]      D_instr_type;
  logic            D_is_jump_instr;
  logic            D_pred_taken;
  logic            D_commit;
  logic [N-1:0]    D_pred_history;

  // statistics
  logic [CW-1:0]   d_count;
  logic [31:0]     d_stall_cnt;

  modport slave (
    input  f_to_d_valid, e_allow_in, fact_success, e_is_jump_instr, e_valid,
           E_opcode, E_rd, F_pc, f_default_pc, f_imm, f_instr, f_opcode,
           f_rd, f_rs1, f_rs2, f_funct, f_instr_type, f_is_jump_instr,
           f_pred_taken, f_pred_history,
    output d_allow_in, d_to_e_valid, D_pc, D_default_pc, D_imm, D_instr,
           D_cur_pc, D_pred_pc, D_opcode, D_rd, D_rs1, D_rs2, D_funct,
           D_instr_type, D_is_jump_instr, D_pred_taken, D_commit,
           D_pred_history, d_count, d_stall_cnt
  );

  modport master (
    output f_to_d_valid, e_allow_in, fact_success, e_is_jump_instr, e_valid,
           E_opcode, E_rd, F_pc, f_default_pc, f_imm, f_instr, f_opcode,
           f_rd, f_rs1, f_rs2, f_funct, f_instr_type, f_is_jump_instr,
           f_pred_taken, f_pred_history,
    input  d_allow_in, d_to_e_valid, D_pc, D_default_pc, D_imm, D_instr,
           D_cur_pc, D_pred_pc, D_opcode, D_rd, D_rs1, D_rs2, D_funct,
           D_instr_type, D_is_jump_instr, D_pred_taken, D_commit,
           D_pred_history, d_count, d_stall_cnt
  );
endinterface

// File: rtl/decode_buffer_stage.sv
// decode_buffer_stage
//   Fetch-to-decode stage built as a DEPTH-entry circular instruction queue.
//   The head entry drives the D_* fields toward execute. d_allow_in is a pure
//   function of occupancy, so there is no combinational e_allow_in path back
//   to fetch. Load-use hazards hold the head; a mispredict flush empties the
//   queue; a saturating counter records load-use stall cycles.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : decode_buffer_stage_if.slave (fetch fields/handshake in, execute
//          feedback in, head fields + d_count + d_stall_cnt out)
module decode_buffer_stage #(
  parameter int DEPTH = 4,
  parameter int N     = 12,
  parameter int XLEN  = 32
) (
  input logic                  clk,
  input logic                  rst,
  decode_buffer_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // instruction-type and opcode encodings shared with the decoder
  localparam logic [2:0] TYPER   = 3'd1;
  localparam logic [2:0] TYPEI   = 3'd2;
  localparam logic [2:0] TYPES   = 3'd3;
  localparam logic [2:0] TYPEB   = 3'd4;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [XLEN-1:0] COMMIT_LO = XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0] COMMIT_HI = XLEN'(32'h87ff_ffff);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] default_pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [9:0]      funct;
    logic [2:0]      instr_type;
    logic            is_jump;
    logic            pred_taken;
    logic [N-1:0]    pred_history;
    logic            commit;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  entry_t        wr_entry;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic not_empty;
  logic allow_in;
  logic use_src1;
  logic use_src2;
  logic load_use;
  logic head_valid;
  logic flush;
  logic push;
  logic pop;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign allow_in  = (count_q != CW'(DEPTH));

  assign use_src1 = (head.instr_type == TYPER) || (head.instr_type == TYPEI) ||
                    (head.instr_type == TYPES) || (head.instr_type == TYPEB);
  assign use_src2 = (head.instr_type == TYPER) || (head.instr_type == TYPES) ||
                    (head.instr_type == TYPEB);

  assign load_use = bus.e_valid && (bus.E_opcode == OP_LOAD) && (bus.E_rd != 5'd0) &&
                    ((use_src1 && (bus.E_rd == head.rs1)) ||
                     (use_src2 && (bus.E_rd == head.rs2)));

  assign head_valid = not_empty && !load_use;
  assign flush      = !bus.fact_success && bus.e_is_jump_instr && bus.e_valid;
  // allow_in is occupancy-only: a pop in the same cycle never frees a full queue
  assign push       = bus.f_to_d_valid && allow_in && !flush;
  assign pop        = head_valid && bus.e_allow_in && !flush;

  always_comb begin
    wr_entry              = '0;
    wr_entry.pc           = bus.F_pc;
    wr_entry.default_pc   = bus.f_default_pc;
    wr_entry.imm          = bus.f_imm;
    wr_entry.instr        = bus.f_instr;
    wr_entry.opcode       = bus.f_opcode;
    wr_entry.rd           = bus.f_rd;
    wr_entry.rs1          = bus.f_rs1;
    wr_entry.rs2          = bus.f_rs2;
    wr_entry.funct        = bus.f_funct;
    wr_entry.instr_type   = bus.f_instr_type;
    wr_entry.is_jump      = bus.f_is_jump_instr;
    wr_entry.pred_taken   = bus.f_pred_taken;
    wr_entry.pred_history = bus.f_pred_history;
    wr_entry.commit       = (bus.F_pc >= COMMIT_LO) && (bus.F_pc <= COMMIT_HI);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (not_empty && load_use && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // entry storage carries no reset; D_* are meaningless while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.d_allow_in      = allow_in;
  assign bus.d_to_e_valid    = head_valid;
  assign bus.D_pc            = head.pc;
  assign bus.D_cur_pc        = head.pc;
  assign bus.D_default_pc    = head.default_pc;
  assign bus.D_pred_pc       = head.default_pc;
  assign bus.D_imm           = head.imm;
  assign bus.D_instr         = head.instr;
  assign bus.D_opcode        = head.opcode;
  assign bus.D_rd            = head.rd;
  assign bus.D_rs1           = head.rs1;
  assign bus.D_rs2           = head.rs2;
  assign bus.D_funct         = head.funct;
  assign bus.D_instr_type    = head.instr_type;
  assign bus.D_is_jump_instr = head.is_jump;
  assign bus.D_pred_taken    = head.pred_taken;
  assign bus.D_commit        = head.commit;
  assign bus.D_pred_history  = head.pred_history;
  assign bus.d_count         = count_q;
  assign bus.d_stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_decode_buffer_stage.sv
module tb_decode_buffer_stage;
  localparam int DEPTH = 4;
  localparam int N     = 12;
  localparam int XLEN  = 32;

  localparam logic [2:0] T_R = 3'd1;
  localparam logic [2:0] T_I = 3'd2;
  localparam logic [2:0] T_S = 3'd3;
  localparam logic [2:0] T_B = 3'd4;
  localparam logic [2:0] T_U = 3'd5;
  localparam logic [6:0] LOAD = 7'b0000011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_buffer_stage_if #(.DEPTH(DEPTH), .N(N), .XLEN(XLEN)) bus ();
  decode_buffer_stage #(.DEPTH(DEPTH), .N(N), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  typ;
    logic        commit;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_stall;
  bit          popped, pushed;
  logic [31:0] pop_act_pc, pop_exp_pc;
  logic        pop_act_commit, pop_exp_commit;
  int          n_pops = 0;

  function automatic bit model_hazard();
    bit u1, u2;
    if (sb.size() == 0) return 1'b0;
    u1 = (sb[0].typ == T_R) || (sb[0].typ == T_I) || (sb[0].typ == T_S) || (sb[0].typ == T_B);
    u2 = (sb[0].typ == T_R) || (sb[0].typ == T_S) || (sb[0].typ == T_B);
    return bus.e_valid && (bus.E_opcode == LOAD) && (bus.E_rd != 5'd0) &&
           ((u1 && bus.E_rd == sb[0].rs1) || (u2 && bus.E_rd == sb[0].rs2));
  endfunction

  task automatic idle();
    bus.f_to_d_valid    = 1'b0;
    bus.e_allow_in      = 1'b0;
    bus.fact_success    = 1'b1;
    bus.e_is_jump_instr = 1'b0;
    bus.e_valid         = 1'b0;
    bus.E_opcode        = 7'd0;
    bus.E_rd            = 5'd0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [2:0] typ,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.f_to_d_valid    = 1'b1;
    bus.F_pc            = pc;
    bus.f_default_pc    = pc + 32'd4;
    bus.f_imm           = ~pc;
    bus.f_instr         = {pc[15:0], 16'h1234};
    bus.f_opcode        = (typ == T_U) ? 7'b0110111 : (typ == T_I) ? 7'b0010011 : 7'b0110011;
    bus.f_rd            = rd;
    bus.f_rs1           = rs1;
    bus.f_rs2           = rs2;
    bus.f_funct         = 10'd0;
    bus.f_instr_type    = typ;
    bus.f_is_jump_instr = (typ == T_B);
    bus.f_pred_taken    = pc[2];
    bus.f_pred_history  = pc[13:2];
  endtask

  // advance one cycle, updating the reference queue from the driven stimulus
  task automatic tick();
    bit   flush, haz, push, pop;
    exp_t e;
    #1;
    flush  = !bus.fact_success && bus.e_is_jump_instr && bus.e_valid;
    haz    = model_hazard();
    push   = bus.f_to_d_valid && (sb.size() < DEPTH) && !flush;
    pop    = (sb.size() != 0) && bus.e_allow_in && !haz && !flush;
    popped = pop;
    pushed = push;
    if ((sb.size() != 0) && haz && !flush && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
    if (pop) begin
      pop_act_pc     = bus.D_pc;
      pop_act_commit = bus.D_commit;
      pop_exp_pc     = sb[0].pc;
      pop_exp_commit = sb[0].commit;
      sb.delete(0);
      n_pops++;
    end
    if (flush) sb.delete();
    else if (push) begin
      e.pc     = bus.F_pc;
      e.rs1    = bus.f_rs1;
      e.rs2    = bus.f_rs2;
      e.typ    = bus.f_instr_type;
      e.commit = (bus.F_pc >= 32'h8000_0000) && (bus.F_pc <= 32'h87ff_ffff);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    bus.e_allow_in = 1'b1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
  endtask

  task automatic test_reset();
    idle();
    offer(32'h0, T_R, 5'd1, 5'd2, 5'd3);
    bus.f_to_d_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_stall = 32'd0;
    #1;
    checks++; if (bus.d_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.d_count); end
    checks++; if (bus.d_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow got=%b exp=1", bus.d_allow_in); end
    checks++; if (bus.d_to_e_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.d_to_e_valid); end
    checks++; if (bus.d_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got=%h exp=0", bus.d_stall_cnt); end
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(32'h8000_0000 + 32'(4 * i), T_R, 5'd6, 5'd1, 5'd2);
      tick();
    end
    offer(32'h8000_0010, T_R, 5'd6, 5'd1, 5'd2);
    #1;
    checks++; if (bus.d_allow_in !== 1'b0) begin errors++; $display("FAIL fill_allow got=%b exp=0", bus.d_allow_in); end
    tick();
    checks++; if (bus.d_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.d_count); end
    checks++; if (bus.D_pc !== 32'h8000_0000) begin errors++; $display("FAIL fill_head_pc got=%h exp=80000000", bus.D_pc); end
    checks++; if (bus.D_commit !== 1'b1) begin errors++; $display("FAIL fill_commit got=%b exp=1", bus.D_commit); end
    checks++; if (bus.D_pred_pc !== 32'h8000_0004) begin errors++; $display("FAIL fill_pred_pc got=%h exp=80000004", bus.D_pred_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] nxt, seq;
    int          start;
    nxt   = 32'h8000_0010;
    seq   = 32'h8000_0000;
    start = n_pops;
    bus.e_allow_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      offer(nxt, T_R, 5'd6, 5'd1, 5'd2);
      tick();
      if (pushed) nxt = nxt + 32'd4;
      if (popped) begin
        checks++;
        if (pop_act_pc !== pop_exp_pc || pop_act_pc !== seq)
          begin errors++; $display("FAIL stream_order got=%h exp=%h", pop_act_pc, seq); end
        seq = seq + 32'd4;
      end
      checks++; if (bus.d_count !== 3'(sb.size())) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", bus.d_count, sb.size()); end
    end
    checks++; if (n_pops - start !== 12) begin errors++; $display("FAIL stream_pops got=%0d exp=12", n_pops - start); end
    drain();
    checks++; if (bus.d_count !== 3'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", bus.d_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] nxt;
    idle();
    nxt = 32'h8000_1000;
    for (int i = 0; i < 2; i++) begin
      offer(nxt, T_R, 5'd6, 5'd1, 5'd2);
      tick();
      nxt = nxt + 32'd4;
    end
    bus.e_allow_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(nxt, T_R, 5'd6, 5'd1, 5'd2);
      tick();
      if (pushed) nxt = nxt + 32'd4;
      checks++; if (bus.d_count !== 3'd2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", bus.d_count); end
      if (popped) begin
        checks++;
        if (pop_act_pc !== pop_exp_pc) begin errors++; $display("FAIL wrap_order got=%h exp=%h", pop_act_pc, pop_exp_pc); end
      end
    end
    drain();
  endtask

  typedef struct {
    logic [2:0] typ;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] erd;
    bit         stall;
  } lu_t;

  task automatic test_load_use();
    lu_t tbl[8];
    tbl[0] = '{T_R, 5'd5, 5'd1, 5'd5, 1'b1};
    tbl[1] = '{T_R, 5'd1, 5'd5, 5'd5, 1'b1};
    tbl[2] = '{T_U, 5'd5, 5'd5, 5'd5, 1'b0};
    tbl[3] = '{T_I, 5'd3, 5'd5, 5'd5, 1'b0};
    tbl[4] = '{T_S, 5'd3, 5'd5, 5'd5, 1'b1};
    tbl[5] = '{T_B, 5'd5, 5'd0, 5'd5, 1'b1};
    tbl[6] = '{T_I, 5'd5, 5'd0, 5'd5, 1'b1};
    tbl[7] = '{T_R, 5'd0, 5'd0, 5'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      idle();
      offer(32'h8000_2000 + 32'(4 * i), tbl[i].typ, 5'd6, tbl[i].rs1, tbl[i].rs2);
      tick();
      bus.f_to_d_valid = 1'b0;
      bus.e_valid      = 1'b1;
      bus.E_opcode     = LOAD;
      bus.E_rd         = tbl[i].erd;
      bus.e_allow_in   = 1'b1;
      #1;
      checks++;
      if (bus.d_to_e_valid !== !tbl[i].stall)
        begin errors++; $display("FAIL lu_valid[%0d] got=%b exp=%b", i, bus.d_to_e_valid, !tbl[i].stall); end
      repeat (2) tick();
      checks++;
      if (bus.d_stall_cnt !== m_stall)
        begin errors++; $display("FAIL lu_stall[%0d] got=%0d exp=%0d", i, bus.d_stall_cnt, m_stall); end
      drain();
    end
    checks++; if (m_stall !== 32'd10 || bus.d_stall_cnt !== 32'd10)
      begin errors++; $display("FAIL lu_total got=%0d exp=10", bus.d_stall_cnt); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      offer(32'h8000_3000 + 32'(4 * i), T_R, 5'd6, 5'd1, 5'd2);
      tick();
    end
    bus.f_to_d_valid = 1'b0;
    #1;
    checks++; if (bus.d_count !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", bus.d_count); end
    offer(32'h8000_3100, T_R, 5'd6, 5'd1, 5'd2);
    bus.e_valid = 1'b1; bus.e_is_jump_instr = 1'b1; bus.fact_success = 1'b0; bus.e_allow_in = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.d_count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.d_count); end
    checks++; if (bus.d_to_e_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.d_to_e_valid); end
    offer(32'h8000_3200, T_R, 5'd6, 5'd1, 5'd2);
    tick();
    bus.f_to_d_valid = 1'b0;
    #1;
    checks++; if (bus.D_pc !== 32'h8000_3200) begin errors++; $display("FAIL flush_head got=%h exp=80003200", bus.D_pc); end
    checks++; if (bus.d_to_e_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%b exp=1", bus.d_to_e_valid); end
    drain();
  endtask

  task automatic test_commit_range();
    logic [31:0] pcs[4];
    logic        exp_c[4];
    int          k;
    pcs[0] = 32'h7fff_ffff; exp_c[0] = 1'b0;
    pcs[1] = 32'h8000_0000; exp_c[1] = 1'b1;
    pcs[2] = 32'h87ff_ffff; exp_c[2] = 1'b1;
    pcs[3] = 32'h8800_0000; exp_c[3] = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(pcs[i], T_U, 5'd6, 5'd0, 5'd0);
      tick();
    end
    idle();
    bus.e_allow_in = 1'b1;
    k = 0;
    for (int c = 0; c < 8 && k < 4; c++) begin
      tick();
      if (popped) begin
        checks++;
        if (pop_act_pc !== pcs[k] || pop_act_commit !== exp_c[k] || pop_act_commit !== pop_exp_commit)
          begin errors++; $display("FAIL commit[%0d] pc got=%h exp=%h commit got=%b exp=%b", k, pop_act_pc, pcs[k], pop_act_commit, exp_c[k]); end
        k++;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL commit_pops got=%0d exp=4", k); end
  endtask

  task automatic test_stall_sat();
    idle();
    offer(32'h8000_5000, T_R, 5'd6, 5'd5, 5'd1);
    tick();
    bus.f_to_d_valid = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFE;
    bus.e_valid = 1'b1; bus.E_opcode = LOAD; bus.E_rd = 5'd5; bus.e_allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.d_stall_cnt !== m_stall || bus.d_stall_cnt !== 32'hFFFF_FFFF)
        begin errors++; $display("FAIL stall_sat[%0d] got=%h exp=ffffffff", i, bus.d_stall_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.e_allow_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(32'h8000_6000 + 32'(4 * i), T_R, 5'd6, 5'd1, 5'd2);
      tick();
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_stall = 32'd0;
    idle();
    #1;
    checks++; if (bus.d_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", bus.d_count); end
    checks++; if (bus.d_stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_stall got=%h exp=0", bus.d_stall_cnt); end
    checks++; if (bus.d_allow_in !== 1'b1) begin errors++; $display("FAIL rst_mid_allow got=%b exp=1", bus.d_allow_in); end
    offer(32'h8000_7000, T_R, 5'd6, 5'd1, 5'd2);
    tick();
    bus.f_to_d_valid = 1'b0;
    #1;
    checks++; if (bus.D_pc !== 32'h8000_7000) begin errors++; $display("FAIL rst_mid_head got=%h exp=80007000", bus.D_pc); end
    checks++; if (bus.d_count !== 3'd1) begin errors++; $display("FAIL rst_mid_count1 got=%0d exp=1", bus.d_count); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_stream();
    test_wrap();
    test_load_use();
    test_flush();
    test_commit_range();
    test_stall_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
